pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with valid/ready handshake. It is the successor to the fixed MEM/WB register: it carries LANES independent DATA_W-bit fields, for example alu_out and ld_data. It adds hold, flush, WFI-drain, an optional skid buffer, and a saturating stall-cycle counter. It sits between any two CPU pipeline stages, and between the core and its AXI-facing memory stages.

---
 rtl/pipe_stage_reg.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, hold, flush, WFI drain and a
// saturating stall counter. Define PIPE_SKID_EN to add a second (skid) entry.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int LANES  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    hold_i,
    input  logic                    flush_i,
    input  logic                    wfi_i,
    output logic                    drained_o,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        stall_cnt_o
);

    localparam int PW = LANES * DATA_W;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [PW-1:0] main_q;
    logic          load_main;
    logic          in_fire;
    logic          out_fire;
    logic [CNT_W-1:0] cnt_q;

    assign out_valid   = (state != ST_EMPTY);
    assign out_data    = main_q;
    assign drained_o   = wfi_i & (state == ST_EMPTY);
    assign stall_cnt_o = cnt_q;

`ifdef PIPE_SKID_EN
    logic [PW-1:0] skid_q;
    logic          load_skid;
    logic          skid_to_main;

    // The skid entry decouples in_ready from out_ready entirely.
    assign in_ready = (state != ST_TWO) & ~hold_i & ~wfi_i & ~flush_i;
`else
    assign in_ready = (~out_valid | out_ready) & ~hold_i & ~wfi_i & ~flush_i;
`endif

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready & ~hold_i;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        load_main    = 1'b0;
`ifdef PIPE_SKID_EN
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
`endif
        if (flush_i) begin
            state_nxt = ST_EMPTY;
        end else if (!hold_i) begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ST_ONE;
                        load_main = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = ST_EMPTY;
`ifdef PIPE_SKID_EN
                    end else if (in_fire) begin
                        state_nxt = ST_TWO;
                        load_skid = 1'b1;
`endif
                    end
                end
`ifdef PIPE_SKID_EN
                ST_TWO: begin
                    if (out_fire) begin
                        state_nxt    = ST_ONE;
                        skid_to_main = 1'b1;
                    end
                end
`endif
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Payload registers are cleared on reset but left alone by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
        end else if (load_main) begin
            main_q <= in_data;
`ifdef PIPE_SKID_EN
        end else if (skid_to_main) begin
            main_q <= skid_q;
`endif
        end
    end

`ifdef PIPE_SKID_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q <= '0;
        end else if (load_skid) begin
            skid_q <= in_data;
        end
    end
`endif

    // Counts cycles where data is presented but not taken; keeps running under hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (out_valid && !out_fire && !flush_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (CNT_W=4 to reach saturation quickly).
// Skid-specific expectations are selected by PIPE_SKID_EN.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int LANES  = 2;
    localparam int CNT_W  = 4;
    localparam int PW     = LANES * DATA_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic          hold_i;
    logic          flush_i;
    logic          wfi_i;
    logic          drained_o;
    logic          cnt_clr;
    logic [CNT_W-1:0] stall_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_stage_reg #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .hold_i(hold_i), .flush_i(flush_i), .wfi_i(wfi_i), .drained_o(drained_o),
        .cnt_clr(cnt_clr), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] pack(input logic [31:0] l1, input logic [31:0] l0);
        return {l1, l0};
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        hold_i = 1'b0; flush_i = 1'b0; wfi_i = 1'b1; cnt_clr = 1'b0;
        #12;
        // ---- Reset state ----
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt_o), 64'd0);
        check("rst_drained_wfi", 64'(drained_o), 64'd1);
        check("rst_in_ready_wfi", 64'(in_ready), 64'd0);
        wfi_i = 1'b0;
        #1;
        check("rst_drained_nowfi", 64'(drained_o), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // ---- Streaming: 1-cycle latency, no bubbles ----
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = pack(32'h22 + i, 32'h11 + i);
            tick();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_data", 64'(out_data), 64'(pack(32'h22 + i, 32'h11 + i)));
        end
        in_valid = 1'b0;
        tick();
        check("stream_empty", 64'(out_valid), 64'd0);
        check("stream_cnt", 64'(stall_cnt_o), 64'd0);

        // ---- Hold ----
        in_valid = 1'b1; in_data = pack(32'h0, 32'hAAAA);
        tick();
        in_valid = 1'b0; hold_i = 1'b1;
        #1;
        check("hold_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) tick();
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_data), 64'(pack(32'h0, 32'hAAAA)));
        check("hold_cnt", 64'(stall_cnt_o), 64'd3);
        hold_i = 1'b0;
        tick();
        check("hold_release", 64'(out_valid), 64'd0);
        check("hold_cnt_after", 64'(stall_cnt_o), 64'd3);
        clear_cnt();
        check("cnt_clr", 64'(stall_cnt_o), 64'd0);

        // ---- Backpressure (skid or single entry) ----
        out_ready = 1'b0; in_valid = 1'b1; in_data = pack(32'hA1, 32'hA0);
        tick();
        in_data = pack(32'hB1, 32'hB0);
        #1;
`ifdef PIPE_SKID_EN
        check("bp_in_ready_one", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("skid_in_ready_two", 64'(in_ready), 64'd0);
        check("skid_head", 64'(out_data), 64'(pack(32'hA1, 32'hA0)));
        tick();
        out_ready = 1'b1;
        check("skid_cnt", 64'(stall_cnt_o), 64'd2);
        check("skid_first", 64'(out_data), 64'(pack(32'hA1, 32'hA0)));
        tick();
        check("skid_second_valid", 64'(out_valid), 64'd1);
        check("skid_second", 64'(out_data), 64'(pack(32'hB1, 32'hB0)));
        check("skid_cnt_after", 64'(stall_cnt_o), 64'd2);
        tick();
        check("skid_empty", 64'(out_valid), 64'd0);
`else
        check("bp_in_ready_one", 64'(in_ready), 64'd0);
        tick();
        check("bp_head", 64'(out_data), 64'(pack(32'hA1, 32'hA0)));
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_pass", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp_second", 64'(out_data), 64'(pack(32'hB1, 32'hB0)));
        check("bp_cnt", 64'(stall_cnt_o), 64'd1);
        tick();
        check("bp_empty", 64'(out_valid), 64'd0);
`endif
        clear_cnt();

        // ---- Flush with hold and new input ----
        out_ready = 1'b0; in_valid = 1'b1; in_data = pack(32'hA1, 32'hA0);
        tick();
`ifdef PIPE_SKID_EN
        in_data = pack(32'hB1, 32'hB0);
        tick();
`endif
        flush_i = 1'b1; hold_i = 1'b1; in_data = pack(32'hC1, 32'hC0);
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush_i = 1'b0; hold_i = 1'b0; in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_data_kept", 64'(out_data), 64'(pack(32'hA1, 32'hA0)));
`ifdef PIPE_SKID_EN
        check("flush_cnt", 64'(stall_cnt_o), 64'd1);
`else
        check("flush_cnt", 64'(stall_cnt_o), 64'd0);
`endif
        out_ready = 1'b1;
        tick();
        check("flush_not_captured", 64'(out_valid), 64'd0);
        clear_cnt();

        // ---- WFI drain ----
        out_ready = 1'b0; in_valid = 1'b1; in_data = pack(32'hD1, 32'hD0);
        tick();
        wfi_i = 1'b1; out_ready = 1'b1; in_data = pack(32'hE1, 32'hE0);
        #1;
        check("wfi_in_ready", 64'(in_ready), 64'd0);
        check("wfi_not_drained", 64'(drained_o), 64'd0);
        check("wfi_emit", 64'(out_data), 64'(pack(32'hD1, 32'hD0)));
        tick();
        check("wfi_empty", 64'(out_valid), 64'd0);
        check("wfi_drained", 64'(drained_o), 64'd1);
        check("wfi_in_ready_after", 64'(in_ready), 64'd0);
        wfi_i = 1'b0; in_valid = 1'b0;
        #1;
        check("wfi_off_drained", 64'(drained_o), 64'd0);

        // ---- Counter saturation then async reset mid-transfer ----
        out_ready = 1'b0; in_valid = 1'b1; in_data = pack(32'hF1, 32'hF0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("cnt_14", 64'(stall_cnt_o), 64'd14);
        for (int i = 0; i < 6; i++) tick();
        check("cnt_sat", 64'(stall_cnt_o), 64'd15);
        out_ready = 1'b1; in_valid = 1'b1; in_data = pack(32'h71, 32'h70);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_data", 64'(out_data), 64'd0);
        check("arst_cnt", 64'(stall_cnt_o), 64'd0);
        tick();
        rst_n = 1'b1; in_data = pack(32'h81, 32'h80);
        tick();
        in_valid = 1'b0;
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_data", 64'(out_data), 64'(pack(32'h81, 32'h80)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
